// File: rtl/line_scaler_buffer.sv
// Ping-pong line buffer with integer horizontal/vertical scaling, PPU pixel stream -> TMDS RGB.
// Optional macro LINEBUF_SCANLINE_EN halves every 8-bit channel on the 2nd and later line repeats.
module line_scaler_buffer #(
    parameter int unsigned      PIX_W     = 24,
    parameter int unsigned      SRC_W     = 256,
    parameter int unsigned      HSCALE    = 2,
    parameter int unsigned      VSCALE    = 2,
    parameter logic [PIX_W-1:0] BLANK_VAL = '0
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             wr_valid_i,
    input  logic [PIX_W-1:0] wr_data_i,
    input  logic             wr_eol_i,
    output logic             wr_ready_o,
    input  logic             rd_hstart_i,
    input  logic             rd_en_i,
    output logic [PIX_W-1:0] rd_data_o,
    output logic             rd_valid_o,
    output logic             overflow_o,
    output logic             underrun_o
);

    localparam int unsigned AW  = (SRC_W > 1) ? $clog2(SRC_W) : 1;
    localparam int unsigned AW1 = AW + 1;
    localparam int unsigned HW  = (HSCALE > 1) ? $clog2(HSCALE) : 1;
    localparam int unsigned RW  = $clog2(VSCALE + 2);

    (* ram_style = "block" *) logic [PIX_W-1:0] mem0 [SRC_W];
    (* ram_style = "block" *) logic [PIX_W-1:0] mem1 [SRC_W];

    logic [1:0]       full_q, full_d;
    logic [AW:0]      len_q [2];
    logic [AW:0]      len_d [2];
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic             drop_q, drop_d;
    logic [RW-1:0]    rep_q, rep_d;
    logic [AW:0]      rd_addr_q, rd_addr_d;
    logic [HW-1:0]    hs_q, hs_d;
    logic [PIX_W-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             ovf_q, ovf_d;
    logic             und_q, und_d;
    logic             wr_we_c;
    logic             rd_ok_c;
    logic [PIX_W-1:0] rd_word_c;
    logic [PIX_W-1:0] rd_pix_c;

    assign wr_ready_o = ~full_q[wr_sel_q];
    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;
    assign overflow_o = ovf_q;
    assign underrun_o = und_q;

    // Next-state: read-side line change first, then write-side completion (a completing write wins).
    always_comb begin
        full_d    = full_q;
        len_d     = len_q;
        wr_sel_d  = wr_sel_q;
        rd_sel_d  = rd_sel_q;
        wr_addr_d = wr_addr_q;
        drop_d    = drop_q;
        rep_d     = rep_q;
        rd_addr_d = rd_addr_q;
        hs_d      = hs_q;
        ovf_d     = ovf_q;
        und_d     = und_q;
        wr_we_c   = 1'b0;

        if (rd_hstart_i) begin
            rd_addr_d = '0;
            hs_d      = '0;
            if (rep_q == RW'(VSCALE) || !full_q[rd_sel_q]) begin
                if (full_q[~rd_sel_q]) begin
                    full_d[rd_sel_q] = 1'b0;
                    rd_sel_d         = ~rd_sel_q;
                    rep_d            = RW'(1);
                end else begin
                    und_d = 1'b1;
                end
            end else begin
                rep_d = rep_q + RW'(1);
            end
        end else if (rd_en_i) begin
            if (hs_q == HW'(HSCALE - 1)) begin
                hs_d = '0;
                if (rd_addr_q != AW1'(SRC_W))
                    rd_addr_d = rd_addr_q + AW1'(1);
            end else begin
                hs_d = hs_q + HW'(1);
            end
        end

        // Pixels past a length-truncated line are swallowed until its eol arrives.
        if (drop_q) begin
            if (wr_valid_i && wr_eol_i)
                drop_d = 1'b0;
        end else if (wr_valid_i) begin
            if (!full_q[wr_sel_q]) begin
                wr_we_c = 1'b1;
                if (wr_eol_i || wr_addr_q == AW'(SRC_W - 1)) begin
                    full_d[wr_sel_q] = 1'b1;
                    len_d[wr_sel_q]  = AW1'(wr_addr_q) + AW1'(1);
                    wr_addr_d        = '0;
                    drop_d           = ~wr_eol_i;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (full_d[wr_sel_q] && !full_d[~wr_sel_q])
            wr_sel_d = ~wr_sel_q;
    end

    // Output pixel selection, with optional scanline darkening of real data.
    always_comb begin
        rd_word_c = rd_sel_q ? mem1[rd_addr_q[AW-1:0]] : mem0[rd_addr_q[AW-1:0]];
        rd_ok_c   = full_q[rd_sel_q] && (rd_addr_q < len_q[rd_sel_q]);
        rd_pix_c  = rd_ok_c ? rd_word_c : BLANK_VAL;
`ifdef LINEBUF_SCANLINE_EN
        if (rd_ok_c && rep_q >= RW'(2)) begin
            for (int i = 0; i < int'(PIX_W / 8); i++)
                rd_pix_c[i*8 +: 8] = {1'b0, rd_word_c[i*8+1 +: 7]};
        end
`endif
    end

    always_ff @(posedge pclk) begin
        if (wr_we_c) begin
            if (wr_sel_q)
                mem1[wr_addr_q] <= wr_data_i;
            else
                mem0[wr_addr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            full_q     <= '0;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b1;
            wr_addr_q  <= '0;
            drop_q     <= 1'b0;
            rep_q      <= '0;
            rd_addr_q  <= '0;
            hs_q       <= '0;
            rd_data_q  <= BLANK_VAL;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            und_q      <= 1'b0;
        end else begin
            full_q     <= full_d;
            len_q      <= len_d;
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            wr_addr_q  <= wr_addr_d;
            drop_q     <= drop_d;
            rep_q      <= rep_d;
            rd_addr_q  <= rd_addr_d;
            hs_q       <= hs_d;
            rd_valid_q <= rd_en_i;
            ovf_q      <= ovf_d;
            und_q      <= und_d;
            if (rd_en_i)
                rd_data_q <= rd_pix_c;
        end
    end

endmodule

// File: tb/tb_line_scaler_buffer.sv
// Bench for line_scaler_buffer: table vectors, directed multi-cycle scenarios, then random
// traffic checked against a line-level reference model.
module tb_line_scaler_buffer;

    localparam int PIX_W = 24;
    localparam int SRC_W = 256;
    localparam int HS    = 2;
    localparam int VS    = 2;

    logic             pclk = 1'b0;
    logic             rst;
    logic             wv, weol, hs, ren;
    logic [PIX_W-1:0] wd;
    logic             wrdy, rv, ovf, und;
    logic [PIX_W-1:0] rdata;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    line_scaler_buffer dut (
        .pclk(pclk), .rst(rst),
        .wr_valid_i(wv), .wr_data_i(wd), .wr_eol_i(weol), .wr_ready_o(wrdy),
        .rd_hstart_i(hs), .rd_en_i(ren), .rd_data_o(rdata), .rd_valid_o(rv),
        .overflow_o(ovf), .underrun_o(und)
    );

    function automatic logic [PIX_W-1:0] shade(input logic [PIX_W-1:0] v, input int rep);
        bit sl;
        sl = 1'b0;
`ifdef LINEBUF_SCANLINE_EN
        sl = 1'b1;
`endif
        return (sl && rep >= 2) ? ((v >> 1) & 24'h7F7F7F) : v;
    endfunction

    // Reference model: whole lines kept as arrays/queues, output index = pixels emitted / HS.
    logic [PIX_W-1:0] mb [2][SRC_W];
    int               mlen [2];
    bit   [1:0]       mfull;
    int               mws, mrs, mrep, mnout;
    logic [PIX_W-1:0] mline [$];
    bit               mdrop, m_rv, m_ovf, m_und;
    logic [PIX_W-1:0] m_rd;

    always @(posedge pclk) begin
        bit ready;
        int idx;
        if (rst) begin
            mfull = '0; mws = 0; mrs = 1; mrep = 0; mnout = 0;
            mline.delete(); mdrop = 0; m_rd = '0; m_rv = 0; m_ovf = 0; m_und = 0;
        end else begin
            ready = !mfull[mws];
            if (ren) begin
                idx  = mnout / HS;
                m_rd = (mfull[mrs] && idx < mlen[mrs]) ? shade(mb[mrs][idx], mrep) : '0;
                mnout++;
            end
            m_rv = ren;
            if (hs) begin
                mnout = 0;
                if (mrep == VS || !mfull[mrs]) begin
                    if (mfull[1-mrs]) begin
                        mfull[mrs] = 0; mrs = 1 - mrs; mrep = 1;
                    end else m_und = 1;
                end else mrep++;
            end
            if (wv) begin
                if (mdrop) begin
                    if (weol) mdrop = 0;
                end else if (!ready) m_ovf = 1;
                else begin
                    mline.push_back(wd);
                    if (weol || mline.size() == SRC_W) begin
                        foreach (mline[i]) mb[mws][i] = mline[i];
                        mlen[mws]  = mline.size();
                        mfull[mws] = 1;
                        mdrop      = !weol;
                        mline.delete();
                    end
                end
            end
            if (mfull[mws] && !mfull[1-mws]) mws = 1 - mws;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic drv(input logic w, input logic [PIX_W-1:0] d, input logic e,
                       input logic h, input logic r);
        wv = w; wd = d; weol = e; hs = h; ren = r;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drv(0, '0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    task automatic write_line(input int n, input logic [PIX_W-1:0] base);
        for (int i = 0; i < n; i++) drv(1, base + PIX_W'(i), (i == n - 1), 0, 0);
    endtask

    task automatic read_check(input string name, input int n, input logic [PIX_W-1:0] base,
                              input int len, input int rep);
        for (int i = 0; i < n; i++) begin
            drv(0, '0, 0, 0, 1);
            check({name, "_data"}, 32'(rdata),
                  32'((i / HS < len) ? shade(base + PIX_W'(i / HS), rep) : '0));
            check({name, "_valid"}, 32'(rv), 32'd1);
        end
    endtask

    task automatic cmp_model();
        check("rnd_data", 32'(rdata), 32'(m_rd));
        check("rnd_valid", 32'(rv), 32'(m_rv));
        check("rnd_wr_ready", 32'(wrdy), 32'(!mfull[mws]));
        check("rnd_overflow", 32'(ovf), 32'(m_ovf));
        check("rnd_underrun", 32'(und), 32'(m_und));
    endtask

    task automatic rnd_in(input int eol_mod);
        wv   = ($urandom_range(0, 3) != 0);
        wd   = PIX_W'($urandom);
        weol = ($urandom_range(0, eol_mod - 1) == 0);
    endtask

    typedef struct {
        logic wv; logic [PIX_W-1:0] wd; logic weol; logic hs; logic ren;
        logic [PIX_W-1:0] e_data; logic e_rv; logic e_rdy; logic e_ovf; logic e_und;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [PIX_W-1:0] d, input logic e,
                                input logic h, input logic r, input logic [PIX_W-1:0] xd,
                                input logic xv, input logic xr, input logic xo, input logic xu);
        vec_t v;
        v.wv = w; v.wd = d; v.weol = e; v.hs = h; v.ren = r;
        v.e_data = xd; v.e_rv = xv; v.e_rdy = xr; v.e_ovf = xo; v.e_und = xu;
        return v;
    endfunction

    initial begin
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [15];
        tbl[0]  = mk(1, 24'h11, 0, 0, 0, 24'h00, 0, 1, 0, 0);
        tbl[1]  = mk(1, 24'h22, 0, 0, 0, 24'h00, 0, 1, 0, 0);
        tbl[2]  = mk(1, 24'h33, 1, 0, 0, 24'h00, 0, 1, 0, 0);
        tbl[3]  = mk(0, 24'h00, 0, 1, 0, 24'h00, 0, 1, 0, 0);
        tbl[4]  = mk(0, 24'h00, 0, 0, 1, 24'h11, 1, 1, 0, 0);
        tbl[5]  = mk(0, 24'h00, 0, 0, 1, 24'h11, 1, 1, 0, 0);
        tbl[6]  = mk(0, 24'h00, 0, 0, 1, 24'h22, 1, 1, 0, 0);
        tbl[7]  = mk(0, 24'h00, 0, 0, 1, 24'h22, 1, 1, 0, 0);
        tbl[8]  = mk(0, 24'h00, 0, 0, 1, 24'h33, 1, 1, 0, 0);
        tbl[9]  = mk(0, 24'h00, 0, 0, 1, 24'h33, 1, 1, 0, 0);
        tbl[10] = mk(0, 24'h00, 0, 0, 1, 24'h00, 1, 1, 0, 0);
        tbl[11] = mk(0, 24'h00, 0, 0, 0, 24'h00, 0, 1, 0, 0);
        tbl[12] = mk(0, 24'h00, 0, 1, 0, 24'h00, 0, 1, 0, 0);
        tbl[13] = mk(0, 24'h00, 0, 1, 0, 24'h00, 0, 1, 0, 1);
        tbl[14] = mk(0, 24'h00, 0, 0, 1, shade(24'h11, 2), 1, 1, 0, 1);

        wv = 0; wd = '0; weol = 0; hs = 0; ren = 0;
        do_reset();
        check("rst_wr_ready", 32'(wrdy), 32'd1);
        check("rst_rd_data", 32'(rdata), 32'd0);
        check("rst_rd_valid", 32'(rv), 32'd0);
        check("rst_overflow", 32'(ovf), 32'd0);
        check("rst_underrun", 32'(und), 32'd0);

        foreach (tbl[i]) begin
            drv(tbl[i].wv, tbl[i].wd, tbl[i].weol, tbl[i].hs, tbl[i].ren);
            check($sformatf("tbl%0d_data", i), 32'(rdata), 32'(tbl[i].e_data));
            check($sformatf("tbl%0d_valid", i), 32'(rv), 32'(tbl[i].e_rv));
            check($sformatf("tbl%0d_wr_ready", i), 32'(wrdy), 32'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_overflow", i), 32'(ovf), 32'(tbl[i].e_ovf));
            check($sformatf("tbl%0d_underrun", i), 32'(und), 32'(tbl[i].e_und));
        end

        // Full-width line, shown three times; third start finds no new line.
        do_reset();
        write_line(SRC_W, '0);
        drv(0, '0, 0, 0, 0);
        check("t1_wr_ready", 32'(wrdy), 32'd1);
        drv(0, '0, 0, 1, 0);
        drv(0, '0, 0, 0, 0);
        read_check("t1_rep1", 2 * SRC_W, '0, SRC_W, 1);
        drv(0, '0, 0, 0, 0);
        check("t1_idle_valid", 32'(rv), 32'd0);
        check("t1_idle_hold", 32'(rdata), 32'(SRC_W - 1));
        drv(0, '0, 0, 1, 0);
        drv(0, '0, 0, 0, 0);
        check("t2_no_underrun", 32'(und), 32'd0);
        read_check("t2_rep2", 2 * SRC_W, '0, SRC_W, 2);
        drv(0, '0, 0, 1, 0);
        check("t2_underrun", 32'(und), 32'd1);
        drv(0, '0, 0, 0, 0);
        read_check("t2_rep3", 2 * SRC_W, '0, SRC_W, 2);

        // Both banks full: writes refused and flagged; freeing start reopens write one cycle later.
        do_reset();
        write_line(4, 24'hA0);
        drv(0, '0, 0, 1, 0);
        write_line(4, 24'hB0);
        check("t3_wr_ready_low", 32'(wrdy), 32'd0);
        check("t3_no_overflow_yet", 32'(ovf), 32'd0);
        for (int i = 0; i < 3; i++) drv(1, 24'hEEEEEE, 0, 0, 0);
        check("t3_overflow", 32'(ovf), 32'd1);
        drv(0, '0, 0, 0, 0);
        read_check("t3_lineA", 8, 24'hA0, 4, 1);
        drv(0, '0, 0, 1, 0);
        check("t3_still_blocked", 32'(wrdy), 32'd0);
        drv(0, '0, 0, 1, 0);
        check("t3_freed_wr_ready", 32'(wrdy), 32'd1);
        check("t3_no_underrun", 32'(und), 32'd0);
        drv(0, '0, 0, 0, 0);
        read_check("t3_lineB", 8, 24'hB0, 4, 1);

        // Short line: blank after the stored pixels.
        do_reset();
        write_line(100, 24'h1000);
        drv(0, '0, 0, 1, 0);
        drv(0, '0, 0, 0, 0);
        read_check("t4_short", 2 * SRC_W, 24'h1000, 100, 1);

        // Reset in the middle of a write and a read.
        do_reset();
        drv(0, '0, 0, 1, 0);
        check("t5_pre_underrun", 32'(und), 32'd1);
        write_line(20, 24'h200);
        drv(0, '0, 0, 1, 0);
        for (int i = 0; i < 50; i++) drv(1, 24'h500 + 24'(i), 0, 0, 1);
        rst = 1'b1;
        drv(1, 24'h777, 0, 0, 1);
        rst = 1'b0;
        check("t5_wr_ready", 32'(wrdy), 32'd1);
        check("t5_rd_data", 32'(rdata), 32'd0);
        check("t5_rd_valid", 32'(rv), 32'd0);
        check("t5_overflow", 32'(ovf), 32'd0);
        check("t5_underrun", 32'(und), 32'd0);
        drv(0, '0, 0, 0, 0);
        write_line(10, 24'h300);
        drv(0, '0, 0, 1, 0);
        drv(0, '0, 0, 0, 0);
        read_check("t5_clean", 20, 24'h300, 10, 1);

        // Scanline repeat: second showing darkened only when the feature is built in.
        do_reset();
        write_line(1, 24'hFF8040);
        drv(0, '0, 0, 1, 0);
        drv(0, '0, 0, 0, 1);
        check("t6_rep1", 32'(rdata), 32'h00FF8040);
        drv(0, '0, 0, 1, 0);
        drv(0, '0, 0, 0, 1);
`ifdef LINEBUF_SCANLINE_EN
        check("t6_rep2", 32'(rdata), 32'h007F4020);
`else
        check("t6_rep2", 32'(rdata), 32'h00FF8040);
`endif

        // Random traffic against the model; second pass forces over-length lines.
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            for (int ln = 0; ln < ((pass == 0) ? 60 : 24); ln++) begin
                hs = 1; ren = 0; rnd_in((pass == 0) ? 16 : 400); tick(); cmp_model();
                hs = 0; ren = 0; rnd_in((pass == 0) ? 16 : 400); tick(); cmp_model();
                for (int c = 0; c < 40; c++) begin
                    ren = ($urandom_range(0, 3) != 0);
                    rnd_in((pass == 0) ? 16 : 400);
                    tick();
                    cmp_model();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
